// File: rtl/cfu_tb_pkg.sv
// Shared definitions for the CFU test sequencer: FSM state type, LFSR tap
// masks and elaboration-time legality helpers.
package cfu_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic bit lfsr_w_legal(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    // Bit i set means 1-based tap i+1 feeds the XNOR.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_D008;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // All-ones is the XNOR lockup state and must never be used as a seed.
    function automatic bit lfsr_seed_legal(input int w, input logic [31:0] seed);
        logic [31:0] ones;
        ones = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (seed & ones) != ones;
    endfunction

endpackage

// File: rtl/cfu_lfsr.sv
// Left-shifting XNOR LFSR with synchronous seed load; reusable stimulus source.
module cfu_lfsr
    import cfu_tb_pkg::*;
#(
    parameter int             W    = 16,
    parameter logic [W-1:0]   SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         adv,
    output logic [W-1:0] q
);

    localparam logic [31:0]  TAPS_ALL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

    logic [W-1:0] r_q;

    generate
        if (!lfsr_w_legal(W)) begin : g_bad_width
            $error("cfu_lfsr: W must be 8, 16 or 32");
        end
        if (!lfsr_seed_legal(W, 32'(SEED))) begin : g_bad_seed
            $error("cfu_lfsr: all-ones SEED locks up an XNOR LFSR");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q <= SEED;
        end else if (adv) begin
            r_q <= {r_q[W-2:0], ~^(r_q & TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cfu_test_sequencer.sv
// Start/run/drain/done sequencer for CFU benches: cycle counter, shared LFSR,
// per-bench stimulus enables, sticky error capture and drain timeout.
module cfu_test_sequencer
    import cfu_tb_pkg::*;
#(
    parameter int                N_BENCH      = 4,
    parameter int                CYCLE_W      = 16,
    parameter int                RUN_CYCLES   = 1000,
    parameter int                DRAIN_CYCLES = 16,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] SEED         = '0,
    parameter bit                STOP_ON_ERR  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_BENCH-1:0] enable_mask,
    input  logic [N_BENCH-1:0] bench_err,
    input  logic [N_BENCH-1:0] bench_idle,
    output logic [CYCLE_W-1:0] cycle,
    output logic [LFSR_W-1:0]  lfsr,
    output logic [N_BENCH-1:0] stim_en,
    output logic               running,
    output logic               done,
    output logic               pass,
    output logic [N_BENCH-1:0] fail_mask,
    output logic               timeout
);

    localparam int                 DC_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CYCLE_W-1:0] RUN_LAST   = CYCLE_W'(RUN_CYCLES - 1);
    localparam logic [DC_W-1:0]    DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

    generate
        if (RUN_CYCLES < 1 || longint'(RUN_CYCLES) > ((longint'(1) << CYCLE_W) - 1)) begin : g_bad_run
            $error("cfu_test_sequencer: RUN_CYCLES out of range for CYCLE_W");
        end
        if (DRAIN_CYCLES < 1) begin : g_bad_drain
            $error("cfu_test_sequencer: DRAIN_CYCLES must be at least 1");
        end
    endgenerate

    seq_state_t         r_state;
    logic [CYCLE_W-1:0] r_cycle;
    logic [DC_W-1:0]    r_drain_cnt;
    logic [N_BENCH-1:0] r_mask;
    logic [N_BENCH-1:0] r_stim_en;
    logic [N_BENCH-1:0] r_fail_mask;
    logic               r_running;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;

    logic               w_start_ok;
    logic               w_err_hit;
    logic               w_all_idle;
    logic               w_run_exit;
    logic [N_BENCH-1:0] w_idle_ok;
    logic [N_BENCH-1:0] w_fail_next;
    logic [CYCLE_W-1:0] w_cycle_sat;
    logic [LFSR_W-1:0]  w_lfsr_q;

    // A disabled bench counts as idle so an empty mask drains in one cycle.
    for (genvar gi = 0; gi < N_BENCH; gi++) begin : g_idle
        assign w_idle_ok[gi] = bench_idle[gi] | ~r_mask[gi];
    end

    assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
    assign w_fail_next = r_fail_mask | (bench_err & r_mask);
    assign w_err_hit   = |(bench_err & r_mask);
    assign w_all_idle  = &w_idle_ok;
    assign w_cycle_sat = (&r_cycle) ? r_cycle : r_cycle + 1'b1;
    assign w_run_exit  = (r_cycle == RUN_LAST) || (STOP_ON_ERR && w_err_hit);

    cfu_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_ok),
        .adv  (r_state == RUN),
        .q    (w_lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cycle     <= '0;
            r_drain_cnt <= '0;
            r_mask      <= '0;
            r_stim_en   <= '0;
            r_fail_mask <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= RUN;
                        r_cycle     <= '0;
                        r_mask      <= enable_mask;
                        r_stim_en   <= enable_mask;
                        r_fail_mask <= '0;
                        r_timeout   <= 1'b0;
                        r_running   <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                RUN: begin
                    r_fail_mask <= w_fail_next;
                    r_cycle     <= w_cycle_sat;
                    if (w_run_exit) begin
                        r_state     <= DRAIN;
                        r_stim_en   <= '0;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    r_fail_mask <= w_fail_next;
                    // Idle takes priority over the timeout on the same edge.
                    if (w_all_idle || r_drain_cnt == DRAIN_LAST) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= !w_all_idle;
                        r_pass    <= (w_fail_next == '0) && w_all_idle;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                        r_cycle     <= w_cycle_sat;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cycle     = r_cycle;
    assign lfsr      = w_lfsr_q;
    assign stim_en   = r_stim_en;
    assign running   = r_running;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign timeout   = r_timeout;

endmodule

// File: doc/cfu_test_sequencer.md
Name: cfu_test_sequencer

Overview:
Parametrised, synthesizable test sequencer for CFU unit benches: owns the run cycle counter, the shared LFSR stimulus source, per-bench enables and pass/fail aggregation.
Replaces the free-running counter/LFSR/$finish pattern with a start/run/drain/done FSM, N bench channels, sticky error capture and a drain timeout.
Sits at the top of a simulation or FPGA self-test; each CFU bench consumes cycle, lfsr and its stim_en bit.

Parameters:
N_BENCH, 4, number of bench channels
CYCLE_W, 16, cycle counter width
RUN_CYCLES, 1000, cycles spent in RUN; 1 ≤ RUN_CYCLES ≤ 2^CYCLE_W−1
DRAIN_CYCLES, 16, max cycles in DRAIN before timeout; ≥1
LFSR_W, 16, LFSR width; legal values 8, 16, 32 only (elaboration error otherwise)
SEED, 0, LFSR initial value; all-ones is illegal (XNOR lockup state)
STOP_ON_ERR, 0, 1 = leave RUN early on first enabled error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a run (sampled in IDLE/DONE)
enable_mask  in  N_BENCH  benches to run, latched on accepted start
bench_err  in  N_BENCH  per-bench error strobe
bench_idle  in  N_BENCH  per-bench quiescent flag
cycle  out  CYCLE_W  cycles since run start
lfsr  out  LFSR_W  shared pseudo-random stimulus
stim_en  out  N_BENCH  per-bench stimulus enable
running  out  1  high in RUN or DRAIN
done  out  1  high in DONE
pass  out  1  valid when done
fail_mask  out  N_BENCH  sticky per-bench error record
timeout  out  1  drain timed out

Behaviour:
- All state changes on posedge clk. rst (any state, mid-run included) → next cycle: IDLE, cycle=0, lfsr=SEED, stim_en=0, running=0, done=0, pass=0, fail_mask=0, timeout=0, latched mask=0.
- LFSR: left shift, new bit0 = XNOR of taps. Taps (1-based): 8→{8,6,5,4}; 16→{16,15,13,4}; 32→{32,22,2,1}. Advances only in RUN. Frozen in DRAIN/DONE; reloaded to SEED on accepted start.
- IDLE: start=1 at edge t → RUN from t+1 with cycle=0, lfsr=SEED, mask latched, stim_en=mask, fail_mask=0, timeout=0.
- RUN: cycle +1 per cycle, saturating at all-ones (never wraps). fail_mask |= bench_err & mask each cycle. Leave RUN when cycle==RUN_CYCLES−1, so RUN lasts exactly RUN_CYCLES cycles. If STOP_ON_ERR=1 and any (bench_err & mask), leave RUN at that edge; the error is recorded at the same edge.
- DRAIN: stim_en=0; cycle keeps counting (saturating); errors still accumulated; internal drain counter starts at 0.
  - If (bench_idle & mask)==mask → DONE next edge, timeout=0.
  - Else if drain counter reaches DRAIN_CYCLES−1 → DONE, timeout=1.
  - If both conditions hold at the same edge, idle wins (timeout=0).
  - mask=0 → DONE after one DRAIN cycle.
- DONE: done=1, running=0, pass=(fail_mask==0)&&!timeout. Outputs hold until rst or start. start in DONE behaves as in IDLE (new run; done and pass drop at t+1).
- start in RUN/DRAIN is ignored. bench_err in IDLE/DONE is ignored.
- All outputs are registered; no combinational input→output paths.

Decomposition:
- Shared package cfu_tb_pkg: state enum {IDLE, RUN, DRAIN, DONE}; tap-mask function/constants indexed by LFSR_W; legality checks for LFSR_W and SEED.
- One sub-module cfu_lfsr (params W, SEED; ports clk, rst, load, adv, q), reusable by other benches.

Test Plan:
- LFSR_W=16, SEED=0, start → lfsr in RUN cycles 0..5 = 0x0000, 0x0001, 0x0003, 0x0007, 0x000F, 0x001E; cycle = 0..5.
- RUN_CYCLES=8, mask=4'b0101, all idle, no errors → stim_en=0101 for exactly 8 cycles, one DRAIN cycle, then done=1, pass=1, timeout=0, cycle=8 at DONE.
- bench_err[2] pulsed at RUN cycle 3, STOP_ON_ERR=0 → RUN completes all 8 cycles; DONE with fail_mask=0100, pass=0. Same pulse on disabled bench[1] → fail_mask=0, pass=1.
- STOP_ON_ERR=1, bench_err[0] at cycle 3 → stim_en drops after cycle 3 (at the cycle 4 position); fail_mask=0001, pass=0.
- DRAIN_CYCLES=16, bench_idle[0] held 0 → DONE after 16 DRAIN cycles with timeout=1, pass=0. Idle rising on the last drain cycle → timeout=0.
- rst asserted at RUN cycle 5 → next cycle all outputs at reset values. start pulses during RUN ignored. start in DONE restarts with lfsr=SEED, fail_mask cleared.
